// File: rtl/ro_adc_edge_counter_if.sv
// Conversion control and result handshake between the ring-oscillator edge
// counter and its consumer. The counter side uses the slave modport.
interface ro_adc_edge_counter_if #(
  parameter int CNT_W  = 12,
  parameter int GATE_W = 16
);
  logic              start;
  logic              continuous;
  logic [GATE_W-1:0] gate_len;
  logic [CNT_W-1:0]  count;
  logic              overflow;
  logic              valid;
  logic              ready;
  logic              busy;

  modport master (
    output start, continuous, gate_len, ready,
    input  count, overflow, valid, busy
  );

  modport slave (
    input  start, continuous, gate_len, ready,
    output count, overflow, valid, busy
  );
endinterface

// File: rtl/ro_adc_edge_counter.sv
// Counts synchronized rising edges of the asynchronous comparator output over
// a programmable gate window and returns a saturating count on valid/ready.
module ro_adc_edge_counter #(
  parameter int CNT_W       = 12,
  parameter int GATE_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 adc_in,
  ro_adc_edge_counter_if.slave bus
);

  // A synchronizer shorter than two flops is not metastability-safe.
  localparam int SS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GATE = 2'd1,
    HOLD = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [SS-1:0]     sync_q;
  logic              hist_q;
  logic              rise;
  logic [CNT_W-1:0]  acc_q, acc_d;
  logic              ovf_q, ovf_d;
  logic [GATE_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              overflow_q, overflow_d;
  logic [CNT_W-1:0]  acc_inc;
  logic              inc_sat;
  logic              arm;

  // Returns {saturated, sum}; the sum sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W:0] sat_add(input logic [CNT_W-1:0] a,
                                             input logic             inc);
    if (inc && (a == CNT_MAX)) begin
      return {1'b1, CNT_MAX};
    end
    return {1'b0, a + CNT_W'(inc)};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SS-2:0], adc_in};
      hist_q <= sync_q[SS-1];
    end
  end

  assign rise = sync_q[SS-1] & ~hist_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      ovf_q      <= 1'b0;
      timer_q    <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      ovf_q      <= ovf_d;
      timer_q    <= timer_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_comb begin
    state_d            = state_q;
    acc_d              = acc_q;
    ovf_d              = ovf_q;
    timer_d            = timer_q;
    count_d            = count_q;
    overflow_d         = overflow_q;
    {inc_sat, acc_inc} = sat_add(acc_q, rise);
    arm                = 1'b0;

    case (state_q)
      IDLE: begin
        arm = bus.start && (bus.gate_len != '0);
      end
      GATE: begin
        acc_d   = acc_inc;
        ovf_d   = ovf_q | inc_sat;
        timer_d = timer_q - GATE_W'(1);
        // Last window cycle: its own edge is folded straight into the result.
        if (timer_q == GATE_W'(1)) begin
          count_d    = acc_inc;
          overflow_d = ovf_q | inc_sat;
          state_d    = HOLD;
        end
      end
      HOLD: begin
        if (bus.ready) begin
          state_d = IDLE;
          arm     = bus.continuous && (bus.gate_len != '0);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (arm) begin
      state_d = GATE;
      acc_d   = '0;
      ovf_d   = 1'b0;
      timer_d = bus.gate_len;
    end
  end

  assign bus.count    = count_q;
  assign bus.overflow = overflow_q;
  assign bus.valid    = (state_q == HOLD);
  assign bus.busy     = (state_q != IDLE);

endmodule

// File: tb/tb_ro_adc_edge_counter.sv
// Bench for ro_adc_edge_counter: window-level reference model compared every
// cycle, plus literal expectations for the directed conversion scenarios.
module tb_ro_adc_edge_counter;
  localparam int CNT_W  = 12;
  localparam int CNT4_W = 4;
  localparam int GATE_W = 16;
  localparam int SS     = 2;
  localparam int MAXC   = (1 << CNT_W) - 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic adc   = 1'b0;

  always #5 clk = ~clk;

  ro_adc_edge_counter_if #(.CNT_W(CNT_W),  .GATE_W(GATE_W)) bus ();
  ro_adc_edge_counter_if #(.CNT_W(CNT4_W), .GATE_W(GATE_W)) bus4 ();

  ro_adc_edge_counter #(.CNT_W(CNT_W), .GATE_W(GATE_W), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst_n(rst_n), .adc_in(adc), .bus(bus)
  );

  ro_adc_edge_counter #(.CNT_W(CNT4_W), .GATE_W(GATE_W), .SYNC_STAGES(SS)) dut4 (
    .clk(clk), .rst_n(rst_n), .adc_in(adc), .bus(bus4)
  );

  int    n_tests = 0;
  int    n_fail  = 0;
  string q_name[$];
  int    q_act[$];
  int    q_exp[$];

  // adc stimulus: held at adc_lvl when adc_per==0, else square wave of period adc_per
  int   adc_per = 0;
  logic adc_lvl = 1'b0;
  int   ph      = 0;

  initial forever begin
    @(posedge clk);
    #1;
    if (adc_per == 0) begin
      adc = adc_lvl;
    end else begin
      adc = (ph < adc_per / 2);
      ph  = (ph + 1) % adc_per;
    end
  end

  task automatic check(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a window of L cycles yields min(edges, MAX) and overflow
  // when more edges arrived than the word can hold. An adc value driven in
  // cycle k shows up as an edge in cycle k+SS.
  int m_phase = 0;  // 0 idle, 1 in window, 2 result pending
  int m_left  = 0;
  int m_n     = 0;
  int m_cnt   = 0;
  int m_ovf   = 0;
  bit d[0:SS+1];

  initial forever begin
    int rise_c;
    @(negedge clk);
    if (!rst_n) begin
      m_phase = 0;
      m_cnt   = 0;
      m_ovf   = 0;
      for (int i = 0; i <= SS + 1; i++) d[i] = 1'b0;
    end
    check("valid",    int'(bus.valid),    int'(m_phase == 2));
    check("busy",     int'(bus.busy),     int'(m_phase != 0));
    check("count",    int'(bus.count),    m_cnt);
    check("overflow", int'(bus.overflow), m_ovf);
    while (q_name.size() > 0) begin
      check(q_name.pop_front(), q_act.pop_front(), q_exp.pop_front());
    end
    if (rst_n) begin
      rise_c = (d[SS-1] && !d[SS]) ? 1 : 0;
      case (m_phase)
        0: if (bus.start && bus.gate_len != '0) begin
             m_phase = 1; m_left = int'(bus.gate_len); m_n = 0;
           end
        1: begin
             m_n += rise_c;
             m_left--;
             if (m_left == 0) begin
               m_phase = 2;
               m_cnt   = (m_n > MAXC) ? MAXC : m_n;
               m_ovf   = (m_n > MAXC) ? 1 : 0;
             end
           end
        default: if (bus.ready) begin
             if (bus.continuous && bus.gate_len != '0) begin
               m_phase = 1; m_left = int'(bus.gate_len); m_n = 0;
             end else begin
               m_phase = 0;
             end
           end
      endcase
      for (int i = SS + 1; i > 0; i--) d[i] = d[i-1];
      d[0] = adc;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic lit(input string nm, input int act, input int exp);
    q_name.push_back(nm);
    q_act.push_back(act);
    q_exp.push_back(exp);
  endtask

  task automatic start_main(input int g);
    bus.gate_len = GATE_W'(g);
    bus.start    = 1'b1;
    tick(1);
    bus.start    = 1'b0;
  endtask

  // lat counts cycles since the start/handshake cycle; l0 is the count already elapsed
  task automatic wait_valid(input int l0, input int budget, output int lat);
    lat = l0;
    while (!bus.valid && lat < budget) begin
      tick(1);
      lat++;
    end
    if (!bus.valid) lit("valid_timeout", 0, 1);
  endtask

  task automatic accept_main();
    bus.ready = 1'b1;
    tick(1);
    bus.ready = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    bus.start  = 1'b0; bus.continuous  = 1'b0; bus.gate_len  = '0; bus.ready  = 1'b0;
    bus4.start = 1'b0; bus4.continuous = 1'b0; bus4.gate_len = '0; bus4.ready = 1'b0;
    rst_n = 1'b0;
    tick(3);
    lit("rst_count", int'(bus.count), 0);
    lit("rst_valid", int'(bus.valid), 0);
    lit("rst_busy",  int'(bus.busy),  0);
    rst_n = 1'b1;

    // 1: period 8, 64-cycle window -> 8 edges, result after 65 cycles
    adc_per = 8;
    tick(20);
    start_main(64);
    wait_valid(1, 200, lat);
    lit("s1_latency", lat, 65);
    lit("s1_count", int'(bus.count), 8);
    lit("s1_ovf", int'(bus.overflow), 0);
    accept_main();
    lit("s1_valid_drop", int'(bus.valid), 0);
    lit("s1_idle", int'(bus.busy), 0);
    lit("s1_count_kept", int'(bus.count), 8);

    // 4: backpressure, then continuous re-arm through the handshake
    start_main(64);
    wait_valid(1, 200, lat);
    tick(10);
    lit("s4_hold_valid", int'(bus.valid), 1);
    lit("s4_hold_busy", int'(bus.busy), 1);
    lit("s4_hold_count", int'(bus.count), 8);
    bus.continuous = 1'b1;
    accept_main();
    bus.continuous = 1'b0;
    lit("s4_rearm_busy", int'(bus.busy), 1);
    lit("s4_rearm_valid", int'(bus.valid), 0);
    wait_valid(1, 200, lat);
    lit("s4_rearm_latency", lat, 65);
    lit("s4_rearm_count", int'(bus.count), 8);
    accept_main();
    lit("s4_end_idle", int'(bus.busy), 0);

    // 6: zero-length start ignored; start during a window ignored
    bus.gate_len = '0;
    bus.start    = 1'b1;
    tick(1);
    bus.start    = 1'b0;
    tick(3);
    lit("s6_zero_busy", int'(bus.busy), 0);
    lit("s6_zero_valid", int'(bus.valid), 0);
    start_main(64);
    tick(10);
    bus.gate_len = GATE_W'(5);
    bus.start    = 1'b1;
    tick(1);
    bus.start    = 1'b0;
    wait_valid(12, 200, lat);
    lit("s6_restart_latency", lat, 65);
    lit("s6_restart_count", int'(bus.count), 8);
    accept_main();

    // 5: reset at window cycle 30 discards the conversion
    start_main(64);
    tick(29);
    rst_n = 1'b0;
    #1;
    lit("s5_rst_valid", int'(bus.valid), 0);
    lit("s5_rst_count", int'(bus.count), 0);
    lit("s5_rst_busy", int'(bus.busy), 0);
    tick(2);
    rst_n = 1'b1;
    tick(20);
    lit("s5_after_busy", int'(bus.busy), 0);
    lit("s5_after_valid", int'(bus.valid), 0);
    start_main(64);
    wait_valid(1, 200, lat);
    lit("s5_fresh_latency", lat, 65);
    lit("s5_fresh_count", int'(bus.count), 8);
    accept_main();

    // 2: constant input produces no edges inside the window
    adc_per = 0;
    adc_lvl = 1'b0;
    tick(10);
    start_main(100);
    wait_valid(1, 300, lat);
    lit("s2_low_latency", lat, 101);
    lit("s2_low_count", int'(bus.count), 0);
    accept_main();
    adc_lvl = 1'b1;
    tick(10);
    start_main(100);
    wait_valid(1, 300, lat);
    lit("s2_high_count", int'(bus.count), 0);
    lit("s2_high_ovf", int'(bus.overflow), 0);
    accept_main();

    // 3: 4-bit counter, period 2 over 40 cycles -> 20 edges saturate at 15
    adc_per = 2;
    tick(10);
    bus4.gate_len = GATE_W'(40);
    bus4.start    = 1'b1;
    tick(1);
    bus4.start    = 1'b0;
    lat = 1;
    while (!bus4.valid && lat < 200) begin
      tick(1);
      lat++;
    end
    if (!bus4.valid) lit("s3_valid_timeout", 0, 1);
    lit("s3_latency", lat, 41);
    lit("s3_count", int'(bus4.count), 15);
    lit("s3_ovf", int'(bus4.overflow), 1);
    bus4.ready = 1'b1;
    tick(1);
    bus4.ready = 1'b0;
    lit("s3_valid_drop", int'(bus4.valid), 0);
    lit("s3_count_kept", int'(bus4.count), 15);

    tick(4);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
